// File: rtl/read_job_sequencer_if.sv
// read_job_sequencer_if: job request, read-master control/buffer and output stream bundle.
// The master modport is the sequencer's view; slave is the surrounding system.
interface read_job_sequencer_if #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 32,
   parameter int LENWIDTH  = 32
);
   logic                 job_valid;
   logic                 job_ready;
   logic [ADDRWIDTH-1:0] job_base;
   logic [LENWIDTH-1:0]  job_length;
   logic                 job_fixed;
   logic                 ctl_fixed_location;
   logic [ADDRWIDTH-1:0] ctl_read_base;
   logic [LENWIDTH-1:0]  ctl_read_length;
   logic                 ctl_go;
   logic                 ctl_done;
   logic                 usr_read_buffer;
   logic [DATAWIDTH-1:0] usr_buffer_data;
   logic                 usr_data_available;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATAWIDTH-1:0] out_data;
   logic                 out_last;
   logic                 job_done;
   logic                 busy;
   modport master (
      input  job_valid, job_base, job_length, job_fixed, ctl_done, usr_buffer_data,
             usr_data_available, out_ready,
      output job_ready, ctl_fixed_location, ctl_read_base, ctl_read_length, ctl_go,
             usr_read_buffer, out_valid, out_data, out_last, job_done, busy
   );
   modport slave (
      output job_valid, job_base, job_length, job_fixed, ctl_done, usr_buffer_data,
             usr_data_available, out_ready,
      input  job_ready, ctl_fixed_location, ctl_read_base, ctl_read_length, ctl_go,
             usr_read_buffer, out_valid, out_data, out_last, job_done, busy
   );
endinterface

// File: rtl/read_job_sequencer.sv
// read_job_sequencer: launches read-master jobs and drains its buffer into a registered stream.
// Completion waits for both the master's done and the last stream word leaving.
module read_job_sequencer #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 32,
   parameter int LENWIDTH  = 32
) (
   input logic clk,
   input logic rst,
   read_job_sequencer_if.master bus
);
   localparam int BPW   = DATAWIDTH / 8;
   localparam int SHIFT = $clog2(BPW);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [ADDRWIDTH-1:0] base_q, base_d;
   logic [LENWIDTH-1:0]  len_q, len_d;
   logic                 fixed_q, fixed_d;
   logic [LENWIDTH-1:0]  words_q, words_d;
   logic                 first_q, first_d;
   logic                 seen_q, seen_d;
   logic [1:0]           cnt_q, cnt_d;
   logic                 rptr_q, rptr_d;
   logic                 wptr_q, wptr_d;
   logic [DATAWIDTH-1:0] data_q [2];
   logic [1:0]           last_q;

   logic                 accept;
   logic                 pop;
   logic                 hs;
   logic                 exit_run;
   logic [LENWIDTH-1:0]  job_words;

   // first_q masks a done level left over from the previous job during the first RUN cycle
   always_comb begin
      accept    = bus.job_valid & (state_q == IDLE) & ~rst;
      job_words = bus.job_length >> SHIFT;
      pop       = (state_q == RUN) & bus.usr_data_available & (words_q != '0) & (cnt_q != 2'd2);
      hs        = (cnt_q != 2'd0) & bus.out_ready;
      exit_run  = (words_q == '0) & (cnt_q == 2'd0) & (seen_q | (bus.ctl_done & ~first_q));
      state_d   = (state_q == IDLE)   ? (accept ? ((job_words == '0) ? DONE : LAUNCH) : IDLE) :
                  (state_q == LAUNCH) ? RUN :
                  (state_q == RUN)    ? (exit_run ? DONE : RUN) : IDLE;
      base_d    = accept ? bus.job_base : base_q;
      len_d     = accept ? bus.job_length : len_q;
      fixed_d   = accept ? bus.job_fixed : fixed_q;
      words_d   = accept ? job_words : words_q - {{(LENWIDTH-1){1'b0}}, pop};
      first_d   = state_q == LAUNCH;
      seen_d    = (state_q == RUN) & (seen_q | (bus.ctl_done & ~first_q));
      cnt_d     = cnt_q + {1'b0, pop} - {1'b0, hs};
      rptr_d    = rptr_q ^ hs;
      wptr_d    = wptr_q ^ pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         len_q   <= '0;
         fixed_q <= 1'b0;
         words_q <= '0;
         first_q <= 1'b0;
         seen_q  <= 1'b0;
         cnt_q   <= 2'd0;
         rptr_q  <= 1'b0;
         wptr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         fixed_q <= fixed_d;
         words_q <= words_d;
         first_q <= first_d;
         seen_q  <= seen_d;
         cnt_q   <= cnt_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         data_q[wptr_q] <= bus.usr_buffer_data;
         last_q[wptr_q] <= words_q == LENWIDTH'(1);
      end
   end

   assign bus.job_ready          = (state_q == IDLE) & ~rst;
   assign bus.ctl_go             = state_q == LAUNCH;
   assign bus.job_done           = state_q == DONE;
   assign bus.busy               = state_q != IDLE;
   assign bus.ctl_read_base      = base_q;
   assign bus.ctl_read_length    = len_q;
   assign bus.ctl_fixed_location = fixed_q;
   assign bus.usr_read_buffer    = pop;
   assign bus.out_valid          = cnt_q != 2'd0;
   assign bus.out_data           = data_q[rptr_q];
   assign bus.out_last           = last_q[rptr_q];
endmodule

// File: tb/tb_read_job_sequencer.sv
// tb_read_job_sequencer: randomized bench with a count-based job/stream reference model.
module tb_read_job_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   read_job_sequencer_if bus ();
   read_job_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0, cyc = 0, jobs = 0;
   logic [31:0] mq[$];
   logic [31:0] sq[$];
   bit act = 0, jd_now = 0, dseen = 0, acc = 0, rd_seen = 0, av_rand = 0;
   int acc_cyc = 0, words = 0, pops = 0, hs = 0, popdone_cyc = 0, drain_cyc = 0;
   int rdy_mode = 0, done_mode = 0, stall = 0;
   logic [31:0] e_base, e_len;
   bit e_fixed;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic drive();
      bus.usr_data_available = (mq.size() > 0) && (!av_rand || $urandom_range(3) != 0);
      bus.usr_buffer_data    = (mq.size() > 0) ? mq[0] : $urandom;
      bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) :
                      (act && cyc >= acc_cyc + 2 + stall);
      bus.ctl_done  = (done_mode == 0) ? (act && words > 0 && pops >= words) :
                      (done_mode == 1) ? (!act || cyc <= acc_cyc + 2 || cyc >= drain_cyc + 3) :
                      (act && cyc == popdone_cyc);
   endtask

   // one clock: check at negedge against the model, advance model, then drive after posedge
   task automatic step();
      int cnt;
      bit e_rd, e_ov, ex, r;
      @(negedge clk);
      r    = rst;
      cnt  = pops - hs;
      e_ov = cnt > 0;
      e_rd = act && words > 0 && cyc >= acc_cyc + 2 && bus.usr_data_available && pops < words && cnt < 2;
      chk("job_ready", bus.job_ready, !act && !rst);
      chk("busy", bus.busy, act);
      chk("ctl_go", bus.ctl_go, act && words > 0 && cyc == acc_cyc + 1);
      chk("job_done", bus.job_done, jd_now);
      chk("out_valid", bus.out_valid, e_ov);
      chk("usr_read_buffer", bus.usr_read_buffer, e_rd);
      if (e_ov) begin
         chk("out_data", bus.out_data, sq[0]);
         chk("out_last", bus.out_last, hs == words - 1);
      end
      if (act && (cyc == acc_cyc + 1 || jd_now)) begin
         chk("ctl_read_base", bus.ctl_read_base, e_base);
         chk("ctl_read_length", bus.ctl_read_length, e_len);
         chk("ctl_fixed_location", bus.ctl_fixed_location, e_fixed);
      end
      rd_seen = bus.usr_read_buffer;
      acc = 0;
      if (r) begin
         act = 0; jd_now = 0; dseen = 0; pops = 0; hs = 0; sq.delete();
      end else begin
         ex = act && !jd_now && words > 0 && cyc >= acc_cyc + 2 && pops == words && hs == words &&
              (dseen || (bus.ctl_done && cyc >= acc_cyc + 3));
         if (act && !jd_now && cyc >= acc_cyc + 3 && bus.ctl_done) dseen = 1;
         if (e_rd) begin
            sq.push_back(bus.usr_buffer_data);
            pops++;
            if (pops == words) popdone_cyc = cyc + 1;
         end
         if (e_ov && bus.out_ready) begin
            void'(sq.pop_front());
            hs++;
            if (hs == words) drain_cyc = cyc + 1;
         end
         if (jd_now) begin
            act = 0;
            jobs++;
         end else if (!act && bus.job_valid) begin
            act = 1; acc = 1; acc_cyc = cyc; dseen = 0; pops = 0; hs = 0;
            e_base = bus.job_base; e_len = bus.job_length; e_fixed = bus.job_fixed;
            words = int'(bus.job_length >> 2);
            popdone_cyc = 1 << 28; drain_cyc = 1 << 28;
         end
         jd_now = ex || (acc && words == 0);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (r) mq.delete();
      else if (rd_seen && mq.size() > 0) void'(mq.pop_front());
      if (acc) bus.job_valid = 1'b0;
      drive();
   endtask

   task automatic run_job(logic [31:0] base, logic [31:0] len, bit fixed, int offer, bit seq_data);
      int start, n;
      start = jobs;
      n = 0;
      mq.delete();
      for (int i = 0; i < offer; i++) mq.push_back(seq_data ? 32'hA0 + 32'(i) : $urandom);
      bus.job_base = base; bus.job_length = len; bus.job_fixed = fixed; bus.job_valid = 1'b1;
      drive();
      while (jobs == start && n < 300) begin
         step();
         n++;
      end
      chk("job_timeout", 64'(jobs == start), 64'd0);
      if (jobs == start) begin
         bus.job_valid = 1'b0;
         rst = 1'b1;
         repeat (2) step();
         rst = 1'b0;
      end
   endtask

   initial begin
      bus.job_valid = 0; bus.job_base = 0; bus.job_length = 0; bus.job_fixed = 0;
      bus.ctl_done = 0; bus.usr_buffer_data = 0; bus.usr_data_available = 0; bus.out_ready = 0;
      repeat (3) step();
      rst = 1'b0;
      step();
      // basic job with a sequential master pattern
      run_job(32'h1000, 16, 0, 4, 1);
      // backpressure: sink stalls for 6 cycles
      rdy_mode = 2; stall = 6;
      run_job(32'h2000, 16, 1, 4, 0);
      // zero-length jobs must not touch the master buffer
      rdy_mode = 0;
      run_job(32'h3000, 0, 0, 2, 0);
      run_job(32'h3004, 3, 0, 2, 0);
      chk("zero_len_untouched", mq.size(), 2);
      // stale done held across accept, then re-raised late
      done_mode = 1;
      run_job(32'h4000, 16, 0, 4, 0);
      // done pulses before the stream drains
      done_mode = 2; rdy_mode = 2; stall = 6;
      run_job(32'h5000, 16, 0, 4, 0);
      // master offers more words than the job asks for
      done_mode = 0; rdy_mode = 0;
      run_job(32'h6000, 8, 0, 3, 0);
      chk("overrun_left", mq.size(), 1);
      // reset in the middle of a stream
      rdy_mode = 1;
      mq.delete();
      for (int i = 0; i < 8; i++) mq.push_back($urandom);
      bus.job_base = 32'h7000; bus.job_length = 32; bus.job_fixed = 0; bus.job_valid = 1'b1;
      drive();
      repeat (6) step();
      rst = 1'b1;
      bus.job_valid = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      repeat (2) step();
      // randomized jobs
      for (int j = 0; j < 25; j++) begin
         int w;
         w = $urandom_range(12);
         done_mode = $urandom_range(2);
         rdy_mode = $urandom_range(2);
         stall = $urandom_range(5);
         av_rand = 1'($urandom_range(1));
         run_job($urandom, 32'(w * 4 + $urandom_range(3)), 1'($urandom_range(1)),
                 w + $urandom_range(2), 0);
         repeat ($urandom_range(2)) step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/read_job_sequencer.md
Name: read_job_sequencer

Overview:
Sits beside the Avalon-MM read master and drives both of its sides. Upstream, it accepts read jobs (base, byte length, fixed-location flag) over a valid/ready handshake and programs and launches the read master through its control port. Downstream, it drains the master's user buffer into a registered valid/ready stream with a last-beat marker. It reports completion only when the master has signalled done and the final word has left the stream.

Parameters:
DATAWIDTH, 32, width of user buffer data and output stream data
ADDRWIDTH, 32, width of job/read base address
LENWIDTH, 32, width of job byte length
BPW, DATAWIDTH/8, bytes per word (local, not overridable)

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
job_valid  in  1  job request valid
job_ready  out  1  sequencer idle, can accept job
job_base  in  ADDRWIDTH  byte start address
job_length  in  LENWIDTH  byte count, multiple of BPW
job_fixed  in  1  read fixed location
ctl_fixed_location  out  1  to read master control
ctl_read_base  out  ADDRWIDTH  to read master control
ctl_read_length  out  LENWIDTH  to read master control
ctl_go  out  1  one-cycle launch pulse
ctl_done  in  1  read master done (level)
usr_read_buffer  out  1  pop head word of master buffer
usr_buffer_data  in  DATAWIDTH  head word (show-ahead)
usr_data_available  in  1  master buffer non-empty
out_valid  out  1  stream word valid
out_ready  in  1  stream sink ready
out_data  out  DATAWIDTH  stream word
out_last  out  1  final word of job
job_done  out  1  one-cycle completion pulse
busy  out  1  state != IDLE

Behaviour:
- Reset (rst high at a clk edge): state IDLE; output buffer emptied; words_left=0; done_seen=0.
- Reset values: ctl_go=0, job_done=0, out_valid=0, usr_read_buffer=0, busy=0, ctl_* registers=0.
- job_ready=0 while rst is high.
- Reset mid-job drops everything in flight. The read master must be reset in the same cycle.
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE: job_ready=1.
  - On job_valid&job_ready, capture base/length/fixed into ctl_* registers and set words_left=job_length/BPW.
  - Low log2(BPW) bits of job_length are ignored.
  - If words_left==0, go to DONE. Otherwise go to LAUNCH.
- LAUNCH: ctl_go=1 for exactly this cycle. Next state is RUN. ctl_* stay stable until the next accept.
- RUN:
  - usr_read_buffer = usr_data_available & (words_left!=0) & (buf_count<2). There is no combinational path from out_ready.
  - Each pop pushes usr_buffer_data into a 2-entry output FIFO and decrements words_left.
  - The pushed entry is tagged last when words_left==1 at pop time.
  - Words available beyond words_left are never popped.
  - done_seen: ctl_done is ignored during LAUNCH and the first RUN cycle (guard for a stale done level). From the second RUN cycle on, ctl_done=1 sets the sticky done_seen.
  - Exit to DONE when words_left==0, buf_count==0 and (done_seen | ctl_done).
- DONE: job_done=1 for one cycle. Next state is IDLE.
- Output FIFO:
  - Head appears on out_data/out_last with out_valid=1. A word popped at edge N is valid from cycle N+1.
  - Handshake is out_valid&out_ready.
  - A simultaneous push and handshake keeps the count.
  - Never overflows: push only when count<2 at the start of the cycle.
  - With out_ready held high and data continuously available, throughput is 1 word/cycle.
- out_valid may only fall after a handshake. out_data is stable while out_valid=1 and out_ready=0.
- Zero-length job: no ctl_go, no stream beats. job_done is the cycle after accept.
- busy=1 in LAUNCH/RUN/DONE.

Test Plan:
- Reset: hold rst 3 cycles mid-stream -> ctl_go, usr_read_buffer, out_valid, job_done, busy all 0. job_ready=1 the cycle after rst falls.
- Basic job: base=0x1000, length=16, fixed=0, out_ready=1, master supplies 0xA0..0xA3 back-to-back, ctl_done rises after the 4th pop.
  - Expect ctl_go for one cycle, the cycle after accept, with ctl_read_base=0x1000 and ctl_read_length=16.
  - Expect 4 beats 0xA0..0xA3 on consecutive cycles, out_last only on 0xA3.
  - Expect one job_done pulse, then job_ready=1.
- Backpressure: length=16, out_ready=0 for 6 cycles with 4 words available -> exactly 2 pops then usr_read_buffer=0. After out_ready=1, the remaining 2 words follow in order with no loss or duplication.
- Zero length: length=0 (or 3 with BPW=4) -> no ctl_go, no out_valid, job_done the cycle after accept.
- Done ordering:
  - ctl_done already high at accept and held -> not treated as done until the second RUN cycle.
  - ctl_done pulsing before the last word drains -> job_done only after the final out handshake.
- Overrun guard: length=8, master offers 3 words -> 2 popped, third left (usr_read_buffer never high for it), job_done issued.
